// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port unified memory.
// Requester 0 is the core, requester 1 the loader/debug port. Accesses are
// serialised round-robin, with a bounded lock that lets an owner keep the bus
// for back-to-back grants until the other side has waited long enough.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAXHOLD = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_req0,
  input  logic          i_req1,
  input  logic          i_we0,
  input  logic          i_we1,
  input  logic          i_lock0,
  input  logic          i_lock1,
  input  logic [AW-1:0] i_addr0,
  input  logic [AW-1:0] i_addr1,
  input  logic [DW-1:0] i_wdata0,
  input  logic [DW-1:0] i_wdata1,
  output logic          o_gnt0,
  output logic          o_gnt1,
  output logic          o_rvalid0,
  output logic          o_rvalid1,
  output logic [DW-1:0] o_rdata,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_adr,
  output logic [DW-1:0] o_mem_wd,
  input  logic [DW-1:0] i_mem_rd
);

  localparam int HW = $clog2(MAXHOLD + 1);
  localparam logic [HW:0] HOLD_LIMIT = MAXHOLD[HW:0];

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_owner;
  logic          w_owner_next;
  logic          r_last;
  logic [HW-1:0] r_hold_cnt;
  logic [HW-1:0] w_hold_next;
  logic [DW-1:0] r_rdata;
  logic          r_rvalid0;
  logic          r_rvalid1;

  logic          w_req_own;
  logic          w_req_other;
  logic          w_we_own;
  logic          w_lock_own;
  logic [AW-1:0] w_addr_own;
  logic [DW-1:0] w_wdata_own;
  logic          w_gnt;
  logic [HW:0]   w_hold_inc;
  logic          w_at_limit;
  logic [HW-1:0] w_hold_sat;
  logic          w_stay;

  assign w_req_own   = r_owner ? i_req1   : i_req0;
  assign w_req_other = r_owner ? i_req0   : i_req1;
  assign w_we_own    = r_owner ? i_we1    : i_we0;
  assign w_lock_own  = r_owner ? i_lock1  : i_lock0;
  assign w_addr_own  = r_owner ? i_addr1  : i_addr0;
  assign w_wdata_own = r_owner ? i_wdata1 : i_wdata0;

  // A grant happens only while the owner still requests; reset vetoes it so a
  // write in the reset cycle never reaches memory.
  assign w_gnt = (r_state == ACCESS) && w_req_own && !i_reset;

  // The hold count is computed one bit wider so the +1 can never wrap, then
  // saturated back into the register width.
  assign w_hold_inc = {1'b0, r_hold_cnt} + 1'b1;
  assign w_at_limit = (w_hold_inc >= HOLD_LIMIT);
  assign w_hold_sat = w_at_limit ? HOLD_LIMIT[HW-1:0] : w_hold_inc[HW-1:0];
  assign w_stay     = w_lock_own && !(w_at_limit && w_req_other);

  // Next-state, owner selection, hold counting and memory-side outputs.
  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_hold_next  = r_hold_cnt;
    o_gnt0       = 1'b0;
    o_gnt1       = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_adr    = '0;
    o_mem_wd     = '0;
    case (r_state)
      IDLE: begin
        if (i_req0 && i_req1) begin
          w_owner_next = ~r_last;
          w_state_next = ACCESS;
        end else if (i_req0) begin
          w_owner_next = 1'b0;
          w_state_next = ACCESS;
        end else if (i_req1) begin
          w_owner_next = 1'b1;
          w_state_next = ACCESS;
        end
      end
      ACCESS: begin
        o_mem_adr = w_addr_own;
        o_mem_wd  = w_wdata_own;
        if (w_req_own) begin
          o_gnt0      = ~r_owner;
          o_gnt1      = r_owner;
          o_mem_we    = w_we_own;
          w_hold_next = w_hold_sat;
          if (!w_stay) begin
            w_state_next = IDLE;
            w_hold_next  = '0;
          end
        end else begin
          w_state_next = IDLE;
          w_hold_next  = '0;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (i_reset) begin
      o_gnt0    = 1'b0;
      o_gnt1    = 1'b0;
      o_mem_we  = 1'b0;
      o_mem_adr = '0;
      o_mem_wd  = '0;
    end
  end

  // Arbitration state: FSM, owner, last winner and hold count.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_owner    <= w_owner_next;
      r_hold_cnt <= w_hold_next;
      if (w_gnt) r_last <= r_owner;
    end
  end

  // Read return path: capture memory data on a read grant and pulse rvalid.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rdata   <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_gnt && !w_we_own && !r_owner;
      r_rvalid1 <= w_gnt && !w_we_own && r_owner;
      if (w_gnt && !w_we_own) r_rdata <= i_mem_rd;
    end
  end

  assign o_rdata   = r_rdata;
  assign o_rvalid0 = r_rvalid0 && !i_reset;
  assign o_rvalid1 = r_rvalid1 && !i_reset;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction-level model of who owns
// the memory each cycle, a shadow memory for read data, directed scenarios
// with literal expectations, then a randomized run.
module tb_mem_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int MAXHOLD = 4;
  localparam int BOUND   = 2 * MAXHOLD + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req   [2];
  logic          we    [2];
  logic          lock  [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];

  logic          gnt0, gnt1, rv0, rv1;
  logic [DW-1:0] rdata;
  logic          memWe;
  logic [AW-1:0] memAdr;
  logic [DW-1:0] memWd;
  logic [DW-1:0] memRd;

  logic [DW-1:0] memArr [64];
  logic          memClear;

  int total = 0;
  int bad   = 0;

  // Model state: is the bus held, by whom, who won last, grants in a row.
  bit            busy;
  int            ownerM;
  int            lastM;
  int            streak;
  logic [DW-1:0] rdReg;
  bit            pendRv [2];
  logic [DW-1:0] shadow [64];

  // Model expectations and DUT samples of the current cycle.
  bit            eGnt [2];
  bit            eRv  [2];
  bit            eWe;
  logic [AW-1:0] eAdr;
  logic [DW-1:0] eWd;
  logic [DW-1:0] eRdata;
  bit            sGnt [2];
  int            waitCnt [2];

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .MAXHOLD(MAXHOLD)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_req0(req[0]), .i_req1(req[1]),
    .i_we0(we[0]), .i_we1(we[1]),
    .i_lock0(lock[0]), .i_lock1(lock[1]),
    .i_addr0(addr[0]), .i_addr1(addr[1]),
    .i_wdata0(wdata[0]), .i_wdata1(wdata[1]),
    .o_gnt0(gnt0), .o_gnt1(gnt1),
    .o_rvalid0(rv0), .o_rvalid1(rv1),
    .o_rdata(rdata),
    .o_mem_we(memWe), .o_mem_adr(memAdr), .o_mem_wd(memWd),
    .i_mem_rd(memRd)
  );

  // Memory behind the arbiter: combinational read, write on the clock edge.
  assign memRd = memArr[memAdr[7:2]];
  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < 64; i++) memArr[i] <= '0;
    end else if (memWe) begin
      memArr[memAdr[7:2]] <= memWd;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Work out what this cycle must look like, then advance the model.
  task automatic modelCycle();
    bit newPend [2];
    int o;
    int idx;
    bit keep;
    eGnt[0] = 0; eGnt[1] = 0;
    eWe = 0; eAdr = '0; eWd = '0;
    eRv[0] = reset ? 1'b0 : pendRv[0];
    eRv[1] = reset ? 1'b0 : pendRv[1];
    eRdata = rdReg;
    newPend[0] = 0; newPend[1] = 0;
    if (memClear) for (int i = 0; i < 64; i++) shadow[i] = '0;
    if (reset) begin
      busy = 0; lastM = 1; streak = 0; rdReg = '0;
    end else if (!busy) begin
      if (req[0] && req[1]) begin ownerM = 1 - lastM; busy = 1; end
      else if (req[0]) begin ownerM = 0; busy = 1; end
      else if (req[1]) begin ownerM = 1; busy = 1; end
    end else begin
      o = ownerM;
      eAdr = addr[o];
      eWd = wdata[o];
      if (req[o]) begin
        eGnt[o] = 1;
        eWe = we[o];
        idx = int'(addr[o][7:2]);
        keep = lock[o] && !((streak + 1 >= MAXHOLD) && req[1-o]);
        lastM = o;
        streak = (streak + 1 > MAXHOLD) ? MAXHOLD : streak + 1;
        if (we[o]) shadow[idx] = wdata[o];
        else begin rdReg = shadow[idx]; newPend[o] = 1; end
        if (!keep) begin busy = 0; streak = 0; end
      end else begin
        busy = 0; streak = 0;
      end
    end
    pendRv[0] = newPend[0];
    pendRv[1] = newPend[1];
  endtask

  task automatic checkOutput();
    chk("gnt0", gnt0, eGnt[0]);
    chk("gnt1", gnt1, eGnt[1]);
    chk("rvalid0", rv0, eRv[0]);
    chk("rvalid1", rv1, eRv[1]);
    chk("rdata", rdata, eRdata);
    chk("mem_we", memWe, eWe);
    chk("mem_adr", memAdr, eAdr);
    chk("mem_wd", memWd, eWd);
    chk("gnt_exclusive", gnt0 & gnt1, 0);
    sGnt[0] = gnt0;
    sGnt[1] = gnt1;
    for (int r = 0; r < 2; r++) begin
      if (reset || !req[r]) waitCnt[r] = 0;
      else if (sGnt[r]) begin
        total++;
        if (waitCnt[r] > BOUND) begin
          bad++;
          $display("[TB] FAIL fairness req%0d actual=%0d cycles required<=%0d", r, waitCnt[r], BOUND);
        end
        waitCnt[r] = 0;
      end else waitCnt[r]++;
    end
  endtask

  // One clock: evaluate mid-cycle, check, then move past the next edge.
  task automatic step();
    @(negedge clk);
    modelCycle();
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic newReq(input int r);
    req[r]   = 1;
    we[r]    = 1'($urandom_range(0, 1));
    lock[r]  = 1'($urandom_range(0, 1));
    addr[r]  = AW'({$urandom_range(0, 63), 2'b00});
    wdata[r] = $urandom;
  endtask

  task automatic applyStimulus();
    reset = ($urandom_range(0, 299) == 0);
    for (int r = 0; r < 2; r++) begin
      if (req[r]) begin
        if (sGnt[r]) begin
          if ($urandom_range(0, 1) == 1) newReq(r);
          else req[r] = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        newReq(r);
      end
    end
  endtask

  task automatic setReq(input int r, input bit rq, input bit w, input bit lk,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[r] = rq; we[r] = w; lock[r] = lk; addr[r] = a; wdata[r] = d;
  endtask

  task automatic doReset();
    reset = 1;
    setReq(0, 0, 0, 0, '0, '0);
    setReq(1, 0, 0, 0, '0, '0);
    step();
    reset = 0;
  endtask

  initial begin
    bit g0 [7];
    bit g1 [7];
    busy = 0; ownerM = 0; lastM = 1; streak = 0; rdReg = '0;
    pendRv[0] = 0; pendRv[1] = 0;
    waitCnt[0] = 0; waitCnt[1] = 0;
    sGnt[0] = 0; sGnt[1] = 0;
    memClear = 1;
    doReset();
    reset = 1;
    step();
    memClear = 0;
    reset = 0;
    chk("reset gnt0", eGnt[0], 0);
    chk("reset rdata", eRdata, 0);

    // Single write from requester 0.
    setReq(0, 1, 1, 0, 32'h10, 32'hDEADBEEF);
    step();
    step();
    chk("t1 gnt0", eGnt[0], 1);
    chk("t1 mem_we", eWe, 1);
    chk("t1 mem_adr", eAdr, 32'h10);
    chk("t1 mem_wd", eWd, 32'hDEADBEEF);
    req[0] = 0;
    step();
    chk("t1 idle mem_we", eWe, 0);
    chk("t1 rvalid0", eRv[0], 0);

    // Requester 1 seeds 0x20, then reads it back.
    setReq(1, 1, 1, 0, 32'h20, 32'h12345678);
    step(); step();
    req[1] = 0;
    step();
    setReq(1, 1, 0, 0, 32'h20, '0);
    step();
    step();
    chk("t2 gnt1", eGnt[1], 1);
    req[1] = 0;
    step();
    chk("t2 rvalid1", eRv[1], 1);
    chk("t2 rdata", eRdata, 32'h12345678);
    chk("t2 rvalid0", eRv[0], 0);
    step();
    chk("t2 rvalid1 pulse", eRv[1], 0);

    // Unlocked contention alternates starting with requester 0.
    doReset();
    setReq(0, 1, 0, 0, 32'h40, '0);
    setReq(1, 1, 0, 0, 32'h44, '0);
    for (int c = 0; c < 6; c++) begin
      step();
      g0[c] = eGnt[0];
      g1[c] = eGnt[1];
    end
    chk("t3 gnt0 pattern", {g0[0], g0[1], g0[2], g0[3], g0[4], g0[5]}, 6'b010001);
    chk("t3 gnt1 pattern", {g1[0], g1[1], g1[2], g1[3], g1[4], g1[5]}, 6'b000100);

    // Locked owner is cut off after MAXHOLD grants when the other waits.
    doReset();
    setReq(0, 1, 0, 1, 32'h50, '0);
    setReq(1, 1, 0, 0, 32'h54, '0);
    for (int c = 0; c < 7; c++) begin
      step();
      g0[c] = eGnt[0];
      g1[c] = eGnt[1];
    end
    chk("t4 gnt0 pattern", {g0[0], g0[1], g0[2], g0[3], g0[4], g0[5], g0[6]}, 7'b0111100);
    chk("t4 gnt1 pattern", {g1[0], g1[1], g1[2], g1[3], g1[4], g1[5], g1[6]}, 7'b0000001);

    // Locked owner with nobody waiting keeps the bus indefinitely.
    doReset();
    setReq(0, 1, 0, 1, 32'h58, '0);
    step();
    for (int c = 0; c < 10; c++) begin
      step();
      chk("t4b gnt0 streak", eGnt[0], 1);
    end

    // Reset in a write grant cycle suppresses the write; priority restarts.
    doReset();
    setReq(0, 1, 1, 0, 32'h30, 32'hCAFEF00D);
    step();
    reset = 1;
    step();
    chk("t5 reset mem_we", eWe, 0);
    reset = 0;
    setReq(1, 1, 0, 0, 32'h30, '0);
    step();
    chk("t5 gnt after reset", eGnt[0] | eGnt[1], 0);
    chk("t5 rvalid after reset", eRv[0] | eRv[1], 0);
    chk("t5 rdata after reset", eRdata, 0);
    step();
    chk("t5 req0 wins", eGnt[0], 1);
    req[0] = 0;
    step();
    step();
    chk("t5 gnt1 read", eGnt[1], 1);
    req[1] = 0;
    reset = 1;
    step();
    chk("t5 rvalid cancelled", eRv[1], 0);
    reset = 0;

    // Owner drops its request mid-access; the waiting requester follows.
    doReset();
    setReq(0, 1, 0, 0, 32'h60, '0);
    setReq(1, 1, 0, 0, 32'h64, '0);
    step();
    req[0] = 0;
    step();
    chk("t6 no gnt0", eGnt[0], 0);
    chk("t6 no mem_we", eWe, 0);
    step();
    step();
    chk("t6 gnt1 later", eGnt[1], 1);
    req[1] = 0;
    step();

    // Randomized traffic.
    doReset();
    for (int c = 0; c < 4000; c++) begin
      applyStimulus();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter for the single-port unified instruction/data memory: asynchronous read, write on posedge clk, word-addressed by A[31:2].
- Requester 0 is the multicycle processor. Requester 1 is a program loader/debug port that writes or inspects memory while the core runs.
- The block serialises accesses using round-robin priority and a bounded lock for back-to-back tenure.
- Read data is registered and returned with a one-cycle valid pulse to the winning requester.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- MAXHOLD, 4, maximum consecutive locked grants before forced rotation when the other requester is waiting. Must be ≥1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  access request; held high until the matching gnt is seen.
- we0 / we1  in  1  1 = write, 0 = read; valid while req is high.
- lock0 / lock1  in  1  request to keep ownership for the following cycle.
- addr0 / addr1  in  AW  byte address.
- wdata0 / wdata1  in  DW  write data.
- gnt0 / gnt1  out  1  one-cycle pulse; the access is performed in this cycle.
- rvalid0 / rvalid1  out  1  one-cycle pulse, the cycle after a read grant.
- rdata  out  DW  registered read data, shared by both requesters and qualified by rvalidN.
- mem_we  out  1  memory write enable.
- mem_adr  out  AW  memory address.
- mem_wd  out  DW  memory write data.
- mem_rd  in  DW  memory read data (combinational from mem_adr).

Behaviour:
- Everything updates on posedge clk. Reset is synchronous, active-high and overrides all other inputs.
- Values on reset:
  - state = IDLE.
  - last = 1, so requester 0 wins the first tie.
  - hold_cnt = 0.
  - gnt0 = gnt1 = rvalid0 = rvalid1 = 0.
  - rdata = 0.
  - mem_we = 0, mem_adr = 0, mem_wd = 0.
- FSM states are IDLE and ACCESS, plus an owner register (0/1).
- IDLE:
  - gnt = 0, mem_we = 0, mem_adr = 0, mem_wd = 0.
  - If exactly one req is high, that requester becomes owner and the next state is ACCESS.
  - If both are high, owner = !last, then ACCESS.
  - If none is high, stay in IDLE.
- ACCESS:
  - mem_adr = addr_owner, mem_wd = wdata_owner.
  - gnt_owner = req_owner.
  - mem_we = gnt_owner & we_owner.
  - The non-owner gnt is always 0.
- Read data: when gnt_owner & !we_owner, rdata <= mem_rd at the clock edge, and rvalid_owner = 1 in the next cycle only. Writes never raise rvalid.
- On gnt in ACCESS:
  - last <= owner.
  - hold_cnt <= min(hold_cnt + 1, MAXHOLD).
- Exit from ACCESS:
  - Stay in ACCESS with the same owner if lock_owner = 1 AND NOT (hold_cnt + 1 ≥ MAXHOLD AND req_other = 1).
  - Otherwise go to IDLE and clear hold_cnt to 0.
  - If req_owner = 0 while in ACCESS: no gnt, no memory operation, go to IDLE.
- Latency and throughput:
  - Unlocked: request to gnt is 2 cycles when the arbiter is idle. Throughput is 1 access per 2 cycles.
  - Locked: 1 access per cycle, up to MAXHOLD grants while the other requester is waiting; unlimited if the other is idle.
- Fairness: with continuous unlocked contention, grants alternate 0,1,0,1,… The bound is satisfied by construction: a waiting requester is granted within 2·MAXHOLD+2 cycles.
- Lock handoff: the owner must present its next addr/we/wdata with req high in the cycle after gnt. The arbiter does not inspect its own gnt/req pairing beyond this.
- Width rules:
  - mem_adr carries the full byte address; memory word-indexes it.
  - hold_cnt width is clog2(MAXHOLD+1) and saturates, never wraps.
- Reset mid-access:
  - A write in the reset cycle is suppressed (mem_we = 0).
  - A pending rvalid is cancelled.
  - The next arbitration starts from reset priority.
- Simultaneous requests in IDLE never produce two gnts. gnt0 & gnt1 = 0 at all times. At most one mem_we per cycle.

Test Plan:
- Reset, then req0 = 1, we0 = 1, addr0 = 0x10, wdata0 = 0xDEADBEEF at cycle 0 → cycle 1: gnt0 = 1, mem_we = 1, mem_adr = 0x10, mem_wd = 0xDEADBEEF. Cycle 2 (req0 dropped): IDLE, mem_we = 0, rvalid0 = 0.
- req1 = 1 read, addr1 = 0x20, mem model returns 0x12345678 → gnt1 in cycle 1, rdata = 0x12345678 and rvalid1 = 1 in cycle 2 only; rvalid0 stays 0.
- After reset, req0 and req1 both held high, unlocked → gnt0 at cycle 1, gnt1 at cycle 3, gnt0 at cycle 5; never both gnt in one cycle.
- MAXHOLD = 4: lock0 = 1, req0 continuous, req1 = 1 from cycle 0 → gnt0 on cycles 1–4, IDLE at cycle 5, gnt1 at cycle 6. Repeat with req1 = 0 → gnt0 every cycle for 10 cycles.
- reset asserted in an ACCESS cycle with a pending write (req0, we0 = 1) → mem_we = 0 that cycle. Next cycle: gnt = 0, rvalid = 0, rdata = 0. Then with both reqs high, requester 0 wins.
- In ACCESS with owner 0, drop req0 → no gnt0, mem_we = 0, return to IDLE, hold_cnt = 0; pending req1 is granted 2 cycles later.
